// File: rtl/calc_pkg.sv
// Shared types for the calculator key front end and the calculator datapath.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_PLUS  = 2'b01,
      OP_MINUS = 2'b10,
      OP_EQUAL = 2'b11
   } op_code_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DEBOUNCE = 2'b01,
      FIRE     = 2'b10,
      WAIT_REL = 2'b11
   } kf_state_t;

   // Bit positions of the buttons in the packed {equal, minus, plus} vector.
   localparam int BTN_PLUS  = 0;
   localparam int BTN_MINUS = 1;
   localparam int BTN_EQUAL = 2;

   // Priority pick among active-low buttons: plus > minus > equal.
   function automatic op_code_t pick_op(input logic [2:0] btn_n);
      op_code_t op;
      if (!btn_n[BTN_PLUS]) begin
         op = OP_PLUS;
      end else if (!btn_n[BTN_MINUS]) begin
         op = OP_MINUS;
      end else if (!btn_n[BTN_EQUAL]) begin
         op = OP_EQUAL;
      end else begin
         op = OP_NONE;
      end
      return op;
   endfunction

   // True when the button belonging to op is released (high).
   function automatic logic op_released(input op_code_t op, input logic [2:0] btn_n);
      logic rel;
      case (op)
         OP_PLUS:  rel = btn_n[BTN_PLUS];
         OP_MINUS: rel = btn_n[BTN_MINUS];
         OP_EQUAL: rel = btn_n[BTN_EQUAL];
         default:  rel = 1'b1;
      endcase
      return rel;
   endfunction

endpackage

// File: rtl/calc_sync.sv
// Multi-bit flop-chain synchroniser; every bit resets to RST_VAL.
module calc_sync #(
   parameter int N      = 1,
   parameter int STAGES = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] stage_q [STAGES];
   logic [N-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= {N{RST_VAL}};
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/calc_key_frontend.sv
// Key front end: synchronise, debounce and prioritise the operator buttons,
// emitting one registered active-low strobe per press with the captured operand.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | all buttons released and stable, waiting for a press
//   DEBOUNCE | winning button low, counting DB_CYCLES stable cycles
//   FIRE     | press accepted; strobe/op_valid/op_code/operand registered
//   WAIT_REL | waiting for all buttons high for DB_CYCLES consecutive cycles
module calc_key_frontend
   import calc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             btn_plus_n,
   input  logic             btn_minus_n,
   input  logic             btn_equal_n,
   output logic [WIDTH-1:0] operand,
   output logic             plus_n,
   output logic             minus_n,
   output logic             equal_n,
   output logic             op_valid,
   output logic [1:0]       op_code,
   output logic             busy
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

   logic [2:0]       btn_s;
   logic [WIDTH-1:0] sw_s;

   kf_state_t        state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   op_code_t         pend_op_q,  pend_op_d;
   logic             plus_n_q,   plus_n_d;
   logic             minus_n_q,  minus_n_d;
   logic             equal_n_q,  equal_n_d;
   logic             op_valid_q, op_valid_d;
   op_code_t         op_code_q,  op_code_d;
   logic [WIDTH-1:0] operand_q,  operand_d;

   calc_sync #(
      .N       (3),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_btn (
      .clk (clk),
      .rst (rst),
      .d   ({btn_equal_n, btn_minus_n, btn_plus_n}),
      .q   (btn_s)
   );

   calc_sync #(
      .N       (WIDTH),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync_sw (
      .clk (clk),
      .rst (rst),
      .d   (sw_in),
      .q   (sw_s)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_op_d  = pend_op_q;
      plus_n_d   = 1'b1;
      minus_n_d  = 1'b1;
      equal_n_d  = 1'b1;
      op_valid_d = 1'b0;
      op_code_d  = op_code_q;
      operand_d  = operand_q;

      case (state_q)
         IDLE: begin
            if (!(&btn_s)) begin
               pend_op_d = pick_op(btn_s);
               cnt_d     = CNT_LOAD;
               state_d   = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            // Only the latched winner matters here; a bounce aborts silently.
            if (op_released(pend_op_q, btn_s)) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = FIRE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIRE: begin
            op_valid_d = 1'b1;
            op_code_d  = pend_op_q;
            operand_d  = sw_s;
            case (pend_op_q)
               OP_PLUS:  plus_n_d  = 1'b0;
               OP_MINUS: minus_n_d = 1'b0;
               OP_EQUAL: equal_n_d = 1'b0;
               default:  ;
            endcase
            cnt_d   = CNT_LOAD;
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!(&btn_s)) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT_REL;
         end
      endcase
   end

   // Reset lands in WAIT_REL so a button held through reset cannot fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_REL;
         cnt_q      <= CNT_LOAD;
         pend_op_q  <= OP_NONE;
         plus_n_q   <= 1'b1;
         minus_n_q  <= 1'b1;
         equal_n_q  <= 1'b1;
         op_valid_q <= 1'b0;
         op_code_q  <= OP_NONE;
         operand_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_op_q  <= pend_op_d;
         plus_n_q   <= plus_n_d;
         minus_n_q  <= minus_n_d;
         equal_n_q  <= equal_n_d;
         op_valid_q <= op_valid_d;
         op_code_q  <= op_code_d;
         operand_q  <= operand_d;
      end
   end

   assign operand  = operand_q;
   assign plus_n   = plus_n_q;
   assign minus_n  = minus_n_q;
   assign equal_n  = equal_n_q;
   assign op_valid = op_valid_q;
   assign op_code  = op_code_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_calc_key_frontend.sv
// Bench for calc_key_frontend: press/release stream model checked every cycle,
// plus literal timing and strobe-count expectations for the directed scenarios.
module tb_calc_key_frontend;

   localparam int W    = 8;
   localparam int SYNC = 2;
   localparam int DB   = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_in = '0;
   logic         btn_plus_n = 1'b1;
   logic         btn_minus_n = 1'b1;
   logic         btn_equal_n = 1'b1;
   logic [W-1:0] operand;
   logic         plus_n, minus_n, equal_n, op_valid, busy;
   logic [1:0]   op_code;

   calc_key_frontend #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC),
      .DB_CYCLES   (DB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_in       (sw_in),
      .btn_plus_n  (btn_plus_n),
      .btn_minus_n (btn_minus_n),
      .btn_equal_n (btn_equal_n),
      .operand     (operand),
      .plus_n      (plus_n),
      .minus_n     (minus_n),
      .equal_n     (equal_n),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int n_plus = 0, n_minus = 0, n_equal = 0;
   bit check_en = 1'b0;

   // Model: inputs are seen SYNC edges late. A press is accepted once the
   // winning button has been seen low for DB+1 consecutive samples while armed;
   // the strobe appears one edge later. Re-arming needs DB all-high samples.
   logic [2:0]   pipe_btn [SYNC];
   logic [W-1:0] pipe_sw  [SYNC];
   logic [2:0]   obs;
   logic [W-1:0] obs_sw;
   int           phase;       // 0 need release, 1 armed, 2 pressing, 3 accepted
   int           rel_streak, press_streak, cand;
   logic         e_plus_n, e_minus_n, e_equal_n, e_valid, e_busy;
   logic [1:0]   e_code;
   logic [W-1:0] e_operand;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC; i++) begin
            pipe_btn[i] = 3'b111;
            pipe_sw[i]  = '0;
         end
         phase = 0; rel_streak = 0; press_streak = 0; cand = 0;
         e_plus_n = 1; e_minus_n = 1; e_equal_n = 1; e_valid = 0;
         e_code = 2'b00; e_operand = '0; e_busy = 1;
      end else begin
         obs    = pipe_btn[SYNC-1];
         obs_sw = pipe_sw[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) begin
            pipe_btn[i] = pipe_btn[i-1];
            pipe_sw[i]  = pipe_sw[i-1];
         end
         pipe_btn[0] = {btn_equal_n, btn_minus_n, btn_plus_n};
         pipe_sw[0]  = sw_in;
         e_plus_n = 1; e_minus_n = 1; e_equal_n = 1; e_valid = 0;
         case (phase)
            0: begin
               if (obs == 3'b111) rel_streak++;
               else rel_streak = 0;
               if (rel_streak == DB) phase = 1;
            end
            1: begin
               if (obs != 3'b111) begin
                  cand = !obs[0] ? 1 : (!obs[1] ? 2 : 3);
                  press_streak = 1;
                  phase = 2;
               end
            end
            2: begin
               if (!obs[cand-1]) begin
                  press_streak++;
                  if (press_streak == DB + 1) phase = 3;
               end else begin
                  phase = 1;
               end
            end
            default: begin
               e_valid   = 1;
               e_code    = cand[1:0];
               e_operand = obs_sw;
               if (cand == 1) e_plus_n = 0;
               if (cand == 2) e_minus_n = 0;
               if (cand == 3) e_equal_n = 0;
               rel_streak = 0;
               phase = 0;
            end
         endcase
         e_busy = (phase != 1);
      end
   end

   always @(negedge clk) begin
      if (check_en && !rst) begin
         vectors++;
         if ({plus_n, minus_n, equal_n, op_valid, op_code, operand, busy} !==
             {e_plus_n, e_minus_n, e_equal_n, e_valid, e_code, e_operand, e_busy}) begin
            miscompares++;
            $display("FAIL cycle t=%0t got p%b m%b e%b v%b c%b op%h b%b required p%b m%b e%b v%b c%b op%h b%b",
                     $time, plus_n, minus_n, equal_n, op_valid, op_code, operand, busy,
                     e_plus_n, e_minus_n, e_equal_n, e_valid, e_code, e_operand, e_busy);
         end
         if (!plus_n)  n_plus++;
         if (!minus_n) n_minus++;
         if (!equal_n) n_equal++;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int p0, m0, q0;

   initial begin
      tick(1);
      check("rst_busy", busy, 1);
      check("rst_strobes", {plus_n, minus_n, equal_n, op_valid}, 4'b1110);
      tick(2);
      rst = 1'b0;
      check_en = 1'b1;
      tick(10);

      // single plus press held 20 cycles
      sw_in = 8'h2A;
      p0 = n_plus;
      btn_plus_n = 1'b0;
      tick(7);
      check("t2_before_edge7", plus_n, 1);
      tick(1);
      check("t2_plus_strobe", plus_n, 0);
      check("t2_op_valid", op_valid, 1);
      check("t2_op_code", op_code, 2'b01);
      check("t2_operand", operand, 8'h2A);
      tick(12);
      check("t2_single_strobe", n_plus - p0, 1);
      btn_plus_n = 1'b1;
      sw_in = 8'h55;
      tick(10);
      check("t2_operand_held", operand, 8'h2A);

      // bouncy minus: low 2, high 1, low 10
      m0 = n_minus;
      btn_minus_n = 1'b0;
      tick(2);
      btn_minus_n = 1'b1;
      tick(1);
      btn_minus_n = 1'b0;
      tick(7);
      check("t3_before_strobe", minus_n, 1);
      tick(1);
      check("t3_minus_strobe", minus_n, 0);
      check("t3_op_code", op_code, 2'b10);
      tick(2);
      btn_minus_n = 1'b1;
      tick(10);
      check("t3_minus_count", n_minus - m0, 1);

      // simultaneous plus and minus
      p0 = n_plus; m0 = n_minus;
      btn_plus_n = 1'b0; btn_minus_n = 1'b0;
      tick(8);
      check("t4_plus_wins", {plus_n, minus_n}, 2'b01);
      check("t4_op_code", op_code, 2'b01);
      tick(4);
      btn_plus_n = 1'b1; btn_minus_n = 1'b1;
      tick(10);
      check("t4_counts", {n_plus - p0, n_minus - m0}, {32'd1, 32'd0});

      // equal: short release ignored, long release re-arms
      q0 = n_equal;
      btn_equal_n = 1'b0;
      tick(8);
      check("t5_first_strobe", equal_n, 0);
      check("t5_op_code", op_code, 2'b11);
      tick(2);
      btn_equal_n = 1'b1;
      tick(3);
      btn_equal_n = 1'b0;
      tick(10);
      check("t5_short_release", n_equal - q0, 1);
      btn_equal_n = 1'b1;
      tick(6);
      btn_equal_n = 1'b0;
      tick(8);
      check("t5_second_strobe", equal_n, 0);
      check("t5_op_code2", op_code, 2'b11);
      tick(2);
      btn_equal_n = 1'b1;
      tick(10);
      check("t5_equal_count", n_equal - q0, 2);

      // reset mid-debounce
      p0 = n_plus;
      sw_in = 8'h77;
      btn_plus_n = 1'b0;
      tick(4);
      #2 rst = 1'b1;
      #1;
      check("t1_strobes_async", {plus_n, minus_n, equal_n}, 3'b111);
      check("t1_op_valid", op_valid, 0);
      check("t1_op_code", op_code, 2'b00);
      check("t1_operand", operand, 8'h00);
      check("t1_busy", busy, 1);
      btn_plus_n = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      check("t1_no_strobe", n_plus - p0, 0);

      // plus held across reset
      p0 = n_plus;
      btn_plus_n = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(12);
      check("t6_held_no_strobe", n_plus - p0, 0);
      btn_plus_n = 1'b1;
      tick(6);
      btn_plus_n = 1'b0;
      tick(8);
      check("t6_strobe_after_repress", plus_n, 0);
      check("t6_operand", operand, 8'h77);
      tick(2);
      btn_plus_n = 1'b1;
      tick(10);
      check("t6_plus_count", n_plus - p0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
